// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file write arbiter.
// State encoding, port identifiers and default widths.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  localparam logic [7:0] SQUASH_MAX = 8'hFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
// pointer names the port that wins when both request.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] gnt
);

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt = '0;
    gnt[PORT_ALU] = req[PORT_ALU] &
                    (~req[PORT_MEM] | (pointer == PORT_ALU));
    gnt[PORT_MEM] = req[PORT_MEM] &
                    (~req[PORT_ALU] | (pointer == PORT_MEM));
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file write arbiter: post-reset clear sweep, then
// round-robin merge of ALU and load writebacks.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writedata,
  output logic              regwrite,
  output logic              clear_done,
  output logic [7:0]        squash_cnt
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_REGS);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              run;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              sq;

  assign run = (state_q == RUN) & ~rst;

  assign req[PORT_ALU] = alu_valid & run;
  assign req[PORT_MEM] = mem_valid & run;

  rr_arb2 u_arb (
    .req     (req),
    .pointer (ptr_q),
    .gnt     (gnt)
  );

  assign alu_ready = gnt[PORT_ALU];
  assign mem_ready = gnt[PORT_MEM];

  // Index-0 writes are accepted but never reach the register file.
  assign sq = (alu_ready & (alu_rd == '0)) |
              (mem_ready & (mem_rd == '0));

  // Next-state: sweep zeros during CLEAR, forward the winner in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    done_d  = done_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (idx_q == END_IDX) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          rd_d  = idx_q[ADDR_W-1:0];
          wd_d  = '0;
          we_d  = 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (alu_ready) begin
          rd_d  = alu_rd;
          wd_d  = alu_data;
          we_d  = (alu_rd != '0);
          ptr_d = PORT_MEM;
        end else if (mem_ready) begin
          rd_d  = mem_rd;
          wd_d  = mem_data;
          we_d  = (mem_rd != '0);
          ptr_d = PORT_ALU;
        end
        if (sq && (cnt_q != SQUASH_MAX)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ptr_q   <= PORT_MEM;
      rd_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd         = rd_q;
  assign writedata  = wd_q;
  assign regwrite   = we_q;
  assign clear_done = done_q;
  assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus
// random held requests against a cycle-count reference model.
module tb_regfile_wr_arbiter;

  localparam int NR = 32;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic        clear_done;
  logic [7:0]  squash_cnt;

  regfile_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rd         (rd),
    .writedata  (writedata),
    .regwrite   (regwrite),
    .clear_done (clear_done),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset, favoured port, outputs.
  int          k = 0;
  bit          fav_mem = 1'b1;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;
  bit          m_we = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt = 0;
  bit          ga = 1'b0;
  bit          gm = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit run;
    @(negedge clk);
    run = !rst && (k > NR);
    ga = run && alu_valid && (!mem_valid || !fav_mem);
    gm = run && mem_valid && (!alu_valid || fav_mem);
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("mem_ready", 32'(mem_ready), 32'(gm));
    @(posedge clk);
    if (rst) begin
      k = 0; fav_mem = 1'b1; m_rd = '0; m_wd = '0;
      m_we = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else if (k < NR) begin
      m_rd = k[4:0]; m_wd = '0; m_we = 1'b1; k++;
    end else if (k == NR) begin
      m_we = 1'b0; m_done = 1'b1; k++;
    end else if (ga || gm) begin
      m_rd = ga ? alu_rd : mem_rd;
      m_wd = ga ? alu_data : mem_data;
      m_we = (m_rd != 5'd0);
      if (m_rd == 5'd0 && m_cnt < 255) m_cnt++;
      fav_mem = ga;
    end else begin
      m_we = 1'b0;
    end
    #1;
    chk("rd", 32'(rd), 32'(m_rd));
    chk("writedata", writedata, m_wd);
    chk("regwrite", 32'(regwrite), 32'(m_we));
    chk("clear_done", 32'(clear_done), 32'(m_done));
    chk("squash_cnt", 32'(squash_cnt), 32'(m_cnt));
  endtask

  initial begin
    int we_hits;
    int n;
    bit got;
    logic [4:0] seq [6];
    seq[0] = 5'd2; seq[1] = 5'd1; seq[2] = 5'd2;
    seq[3] = 5'd1; seq[4] = 5'd2; seq[5] = 5'd1;

    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // Reset state.
    tick();
    chk("reset_regwrite", 32'(regwrite), 32'd0);
    rst = 1'b0;

    // Idle clear sweep: exactly 32 writes, then clear_done.
    we_hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (regwrite) we_hits++;
    end
    chk("sweep_writes", 32'(we_hits), 32'd32);
    chk("sweep_done", 32'(clear_done), 32'd1);

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("alu_rd", 32'(rd), 32'd5);
    chk("alu_wd", writedata, 32'hDEADBEEF);
    chk("alu_we", 32'(regwrite), 32'd1);
    tick();
    chk("alu_we_drop", 32'(regwrite), 32'd0);

    // Continuous contention alternates starting with mem.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2B2B2;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_seq", 32'(rd), 32'(seq[i]));
    end
    alu_valid = 1'b0;

    // Squashed writes to index 0, counter saturates.
    mem_rd = 5'd0; mem_data = 32'd7;
    we_hits = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (regwrite) we_hits++;
    end
    mem_valid = 1'b0;
    chk("squash_we", 32'(we_hits), 32'd0);
    chk("squash_sat", 32'(squash_cnt), 32'd255);
    tick();
    chk("squash_hold", 32'(squash_cnt), 32'd255);

    // Reset in the middle of the sweep restarts it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("mid_idx", 32'(rd), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 32'(regwrite), 32'd0);
    we_hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (regwrite) we_hits++;
    end
    chk("restart_writes", 32'(we_hits), 32'd32);

    // ALU request held through CLEAR is taken on the first RUN cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h12345678;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      tick();
      n++;
      got = ga;
    end
    alu_valid = 1'b0;
    chk("held_accept_cycle", 32'(n), 32'(NR + 2));
    chk("held_rd", 32'(rd), 32'd9);
    chk("held_wd", writedata, 32'h12345678);

    // Random held requests with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1'b1;
        alu_rd = 5'($urandom_range(0, 31));
        alu_data = $urandom;
      end
      if (!mem_valid && $urandom_range(0, 2) != 0) begin
        mem_valid = 1'b1;
        mem_rd = 5'($urandom_range(0, 31));
        mem_data = $urandom;
      end
      rst = (i == 200);
      tick();
      if (ga) alu_valid = 1'b0;
      if (gm) mem_valid = 1'b0;
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
